// File: rtl/pet_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pet_pkg
// Purpose  : Shared definitions for the pet needs engine: FSM state
//            encoding, default parameter constants and a small width helper.
//            The engine, its tick divider and the display logic import this.
// Revision : 1.0 - initial release
// ============================================================================
package pet_pkg;

    // Engine action FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_COOL  = 2'd2,
        ST_DEAD  = 2'd3
    } pet_state_t;

    // Default parameter constants
    localparam int PET_N_NEEDS     = 3;
    localparam int PET_VAL_W       = 7;
    localparam int PET_MAX_VAL     = 100;
    localparam int PET_TICK_DIV    = 5000000;
    localparam int PET_DECAY_TICKS = 1;
    localparam int PET_LIFE_PLUS   = 70;
    localparam int PET_LIFE_MINUS  = 30;
    localparam int PET_DISEASE_TH  = 20;
    localparam int PET_REFILL      = 25;
    localparam int PET_HEAL_AMT    = 40;
    localparam int PET_COOLDOWN    = 25000000;

    // Bits needed to hold the values 0..n-1, never less than one bit
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pet_pkg
`default_nettype wire

// File: rtl/pet_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pet_tick_gen
// Purpose  : Divides clk down to a one-cycle tick pulse every TICK_DIV
//            cycles. The pulse is registered and appears in the cycle in
//            which the counter has just wrapped back to 0.
// Ports    : clk       in  system clock
//            btn_reset in  asynchronous active-low reset
//            tick      out one-cycle pulse per TICK_DIV clocks
// Revision : 1.0 - initial release
// ============================================================================
module pet_tick_gen
    import pet_pkg::*;
#(
    parameter int TICK_DIV = PET_TICK_DIV
)(
    input  logic clk,
    input  logic btn_reset,
    output logic tick
);

    localparam int               CNT_W  = bits_for(TICK_DIV);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (cnt_q == C_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : pet_tick_gen
`default_nettype wire

// File: rtl/pet_needs_engine.sv
`default_nettype none
// ============================================================================
// Module   : pet_needs_engine
// Purpose  : Virtual-pet state engine. Need channels decay on a slow tick,
//            life drifts up or down with the needs, and a small action FSM
//            accepts refill/heal requests with a button-lockout cooldown.
//            Life reaching zero is terminal until reset.
// Ports    : clk, btn_reset (async active-low)
//            pause                  freeze decay and life drift
//            act_valid/heal/need    action request, act_ready handshake
//            act_err                pulse when an accepted action did nothing
//            needs, life            current values (need 0 in LSBs)
//            disease, death, tick   status flags / tick pulse
// Revision : 1.0 - initial release
// ============================================================================
module pet_needs_engine
    import pet_pkg::*;
#(
    parameter int N_NEEDS     = PET_N_NEEDS,
    parameter int VAL_W       = PET_VAL_W,
    parameter int MAX_VAL     = PET_MAX_VAL,
    parameter int TICK_DIV    = PET_TICK_DIV,
    parameter int DECAY_TICKS = PET_DECAY_TICKS,
    parameter int LIFE_PLUS   = PET_LIFE_PLUS,
    parameter int LIFE_MINUS  = PET_LIFE_MINUS,
    parameter int DISEASE_TH  = PET_DISEASE_TH,
    parameter int REFILL      = PET_REFILL,
    parameter int HEAL_AMT    = PET_HEAL_AMT,
    parameter int COOLDOWN    = PET_COOLDOWN,
    localparam int IDX_W      = bits_for(N_NEEDS)
)(
    input  logic                       clk,
    input  logic                       btn_reset,
    input  logic                       pause,
    input  logic                       act_valid,
    input  logic                       act_heal,
    input  logic [IDX_W-1:0]           act_need,
    output logic                       act_ready,
    output logic                       act_err,
    output logic [N_NEEDS*VAL_W-1:0]   needs,
    output logic [VAL_W-1:0]           life,
    output logic                       disease,
    output logic                       death,
    output logic                       tick
);

    // Life arithmetic is done signed with 4 guard bits so the sum of life,
    // per-need drift and heal can be clamped without wrapping.
    localparam int LW     = VAL_W + 4;
    localparam int DEC_W  = bits_for(DECAY_TICKS);
    localparam int COOL_W = bits_for(COOLDOWN);

    localparam logic [VAL_W-1:0]     C_MAX        = VAL_W'(MAX_VAL);
    localparam logic [VAL_W-1:0]     C_LIFE_PLUS  = VAL_W'(LIFE_PLUS);
    localparam logic [VAL_W-1:0]     C_LIFE_MINUS = VAL_W'(LIFE_MINUS);
    localparam logic [VAL_W-1:0]     C_DISEASE_TH = VAL_W'(DISEASE_TH);
    localparam logic [VAL_W:0]       C_REFILL_X   = (VAL_W+1)'(REFILL);
    localparam logic [VAL_W:0]       C_MAX_X      = (VAL_W+1)'(MAX_VAL);
    localparam logic signed [LW-1:0] C_HEAL_S     = LW'(HEAL_AMT);
    localparam logic signed [LW-1:0] C_MAX_S      = LW'(MAX_VAL);
    localparam logic [DEC_W-1:0]     C_DECAY_LAST = DEC_W'(DECAY_TICKS - 1);
    localparam logic [COOL_W-1:0]    C_COOL_LAST  = COOL_W'(COOLDOWN - 1);
    localparam logic [IDX_W:0]       C_N_NEEDS    = (IDX_W+1)'(N_NEEDS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pet_state_t          state_q, state_d;
    logic [VAL_W-1:0]    needs_q [N_NEEDS];
    logic [VAL_W-1:0]    needs_d [N_NEEDS];
    logic [VAL_W-1:0]    life_q, life_d;
    logic                disease_q, disease_d;
    logic                death_q, death_d;
    logic                ready_en_q, ready_en_d;
    logic                act_heal_q, act_heal_d;
    logic [IDX_W-1:0]    act_need_q, act_need_d;
    logic [DEC_W-1:0]    decay_cnt_q, decay_cnt_d;
    logic [COOL_W-1:0]   cool_cnt_q, cool_cnt_d;

    logic                tick_w;
    logic                frozen_w;
    logic                upd_tick_w;
    logic                do_decay_w;
    logic                in_apply_w;
    logic                idx_ok_w;
    logic                do_refill_w;
    logic                do_heal_w;
    logic signed [LW-1:0] delta_w;
    logic signed [LW-1:0] life_acc_w;

    pet_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .btn_reset (btn_reset),
        .tick      (tick_w)
    );

    // ------------------------------------------------------------------
    // Event qualification
    // ------------------------------------------------------------------
    // Life at zero freezes everything already in that cycle, so a heal or
    // refill cannot sneak in between life hitting 0 and the DEAD state.
    always_comb begin
        frozen_w    = death_q || (life_q == '0);
        upd_tick_w  = tick_w && !pause && !frozen_w;
        in_apply_w  = (state_q == ST_APPLY) && !frozen_w;
        idx_ok_w    = ({1'b0, act_need_q} < C_N_NEEDS);
        do_refill_w = in_apply_w && !act_heal_q && idx_ok_w;
        do_heal_w   = in_apply_w &&  act_heal_q && disease_q;
        act_err     = in_apply_w && (act_heal_q ? !disease_q : !idx_ok_w);
    end

    // Decay divider: counts unpaused ticks
    always_comb begin
        decay_cnt_d = decay_cnt_q;
        do_decay_w  = 1'b0;
        if (upd_tick_w) begin
            if (decay_cnt_q == C_DECAY_LAST) begin
                decay_cnt_d = '0;
                do_decay_w  = 1'b1;
            end else begin
                decay_cnt_d = decay_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Need update: decay first, then refill on the decayed value
    // ------------------------------------------------------------------
    always_comb begin
        logic [VAL_W-1:0] base_v;
        logic [VAL_W:0]   sum_v;
        base_v = '0;
        sum_v  = '0;
        for (int i = 0; i < N_NEEDS; i++) begin
            base_v = needs_q[i];
            if (do_decay_w && (base_v != '0)) begin
                base_v = base_v - 1'b1;
            end
            needs_d[i] = base_v;
            if (do_refill_w && (act_need_q == IDX_W'(i))) begin
                sum_v      = {1'b0, base_v} + C_REFILL_X;
                needs_d[i] = (sum_v > C_MAX_X) ? C_MAX : sum_v[VAL_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Life drift from pre-decay need values, plus heal, clamped
    // ------------------------------------------------------------------
    always_comb begin
        delta_w = '0;
        for (int i = 0; i < N_NEEDS; i++) begin
            if (needs_q[i] >= C_LIFE_PLUS) begin
                delta_w = delta_w + LW'(1);
            end
            if (needs_q[i] <= C_LIFE_MINUS) begin
                delta_w = delta_w - LW'(1);
            end
        end
    end

    always_comb begin
        life_acc_w = $signed({4'b0000, life_q});
        if (upd_tick_w) begin
            life_acc_w = life_acc_w + delta_w;
        end
        if (do_heal_w) begin
            life_acc_w = life_acc_w + C_HEAL_S;
        end
        if (life_acc_w[LW-1]) begin
            life_d = '0;
        end else if (life_acc_w > C_MAX_S) begin
            life_d = C_MAX;
        end else begin
            life_d = life_acc_w[VAL_W-1:0];
        end
    end

    // Flags lag life by one cycle
    always_comb begin
        disease_d  = (life_q <= C_DISEASE_TH);
        death_d    = frozen_w;
        ready_en_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // Action FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        act_heal_d = act_heal_q;
        act_need_d = act_need_q;
        case (state_q)
            ST_IDLE: begin
                if (act_valid && act_ready) begin
                    act_heal_d = act_heal;
                    act_need_d = act_need;
                    state_d    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cool_cnt_d = '0;
                state_d    = ST_COOL;
            end
            ST_COOL: begin
                if (cool_cnt_q == C_COOL_LAST) begin
                    cool_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (frozen_w) begin
            state_d = ST_DEAD;
        end
    end

    // ready_en_q holds act_ready low through reset until the first clock
    assign act_ready = ready_en_q && (state_q == ST_IDLE) && !frozen_w;

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state_q     <= ST_IDLE;
            life_q      <= C_MAX;
            disease_q   <= 1'b0;
            death_q     <= 1'b0;
            ready_en_q  <= 1'b0;
            act_heal_q  <= 1'b0;
            act_need_q  <= '0;
            decay_cnt_q <= '0;
            cool_cnt_q  <= '0;
            for (int i = 0; i < N_NEEDS; i++) begin
                needs_q[i] <= C_MAX;
            end
        end else begin
            state_q     <= state_d;
            life_q      <= life_d;
            disease_q   <= disease_d;
            death_q     <= death_d;
            ready_en_q  <= ready_en_d;
            act_heal_q  <= act_heal_d;
            act_need_q  <= act_need_d;
            decay_cnt_q <= decay_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            for (int i = 0; i < N_NEEDS; i++) begin
                needs_q[i] <= needs_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_NEEDS; g++) begin : g_pack
        assign needs[g*VAL_W +: VAL_W] = needs_q[g];
    end

    assign life    = life_q;
    assign disease = disease_q;
    assign death   = death_q;
    assign tick    = tick_w;

endmodule : pet_needs_engine
`default_nettype wire

// File: tb/tb_pet_needs_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pet_needs_engine
// Purpose  : Directed self-checking bench for pet_needs_engine with
//            TICK_DIV = 4 and COOLDOWN = 3. Expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pet_needs_engine;

    localparam int VW = 7;

    logic            clk       = 1'b0;
    logic            btn_reset = 1'b0;
    logic            pause     = 1'b0;
    logic            act_valid = 1'b0;
    logic            act_heal  = 1'b0;
    logic [1:0]      act_need  = 2'd0;
    logic            act_ready;
    logic            act_err;
    logic [3*VW-1:0] needs;
    logic [VW-1:0]   life;
    logic            disease;
    logic            death;
    logic            tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pet_needs_engine #(
        .TICK_DIV (4),
        .COOLDOWN (3)
    ) dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .pause     (pause),
        .act_valid (act_valid),
        .act_heal  (act_heal),
        .act_need  (act_need),
        .act_ready (act_ready),
        .act_err   (act_err),
        .needs     (needs),
        .life      (life),
        .disease   (disease),
        .death     (death),
        .tick      (tick)
    );

    function automatic logic [31:0] pk(input logic [6:0] n0, input logic [6:0] n1,
                                       input logic [6:0] n2);
        return {11'd0, n2, n1, n0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next tick pulse, then one more edge so its effect shows
    task automatic run_to_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 12);
        chk("tick_seen", {31'd0, tick}, 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_needs",   needs, pk(100, 100, 100));
        chk("rst_life",    life, 32'd100);
        chk("rst_ready",   {31'd0, act_ready}, 32'd0);
        chk("rst_disease", {31'd0, disease}, 32'd0);
        chk("rst_death",   {31'd0, death}, 32'd0);
        chk("rst_tick",    {31'd0, tick}, 32'd0);
        chk("rst_err",     {31'd0, act_err}, 32'd0);

        // ---------------- decay and tick period ----------------
        btn_reset = 1'b1;
        chk("ready_pre_edge", {31'd0, act_ready}, 32'd0);
        step();
        chk("ready_first_edge", {31'd0, act_ready}, 32'd1);
        chk("tick_e1", {31'd0, tick}, 32'd0);
        step();
        step();
        chk("tick_e3", {31'd0, tick}, 32'd0);
        step();
        chk("tick_e4", {31'd0, tick}, 32'd1);
        step();
        chk("needs_t1", needs, pk(99, 99, 99));
        chk("tick_e5", {31'd0, tick}, 32'd0);
        step();
        step();
        step();
        chk("tick_e8", {31'd0, tick}, 32'd1);
        step();
        chk("needs_t2", needs, pk(98, 98, 98));
        chk("life_t2", life, 32'd100);
        repeat (8) run_to_tick();
        chk("needs_t10", needs, pk(90, 90, 90));

        // ---------------- refill saturates, cooldown lockout ----------------
        act_valid = 1'b1;
        act_heal  = 1'b0;
        act_need  = 2'd1;
        step();
        chk("ready_apply", {31'd0, act_ready}, 32'd0);
        act_need = 2'd0;
        step();
        chk("refill_sat", needs, pk(90, 100, 90));
        chk("ready_cool0", {31'd0, act_ready}, 32'd0);
        step();
        chk("ready_cool1", {31'd0, act_ready}, 32'd0);
        step();
        chk("cool_ignored", needs, pk(89, 99, 89));
        chk("ready_cool2", {31'd0, act_ready}, 32'd0);
        step();
        chk("ready_after_cool", {31'd0, act_ready}, 32'd1);
        act_valid = 1'b0;
        step();
        chk("no_late_accept", needs, pk(89, 99, 89));
        chk("ready_idle", {31'd0, act_ready}, 32'd1);

        // ---------------- refill coinciding with decay ----------------
        repeat (39) run_to_tick();
        chk("needs_t50", needs, pk(50, 60, 50));
        chk("life_t50", life, 32'd100);
        step();
        step();
        act_valid = 1'b1;
        act_need  = 2'd0;
        step();
        act_valid = 1'b0;
        step();
        chk("decay_refill", needs, pk(74, 59, 49));

        // ---------------- pause ----------------
        pause = 1'b1;
        run_to_tick();
        chk("paused", needs, pk(74, 59, 49));
        pause = 1'b0;
        run_to_tick();
        chk("unpaused", needs, pk(73, 58, 48));
        chk("life_unpaused", life, 32'd100);

        // ---------------- life decline, heal, disease, death ----------------
        btn_reset = 1'b0;
        #1;
        chk("rst2_needs", needs, pk(100, 100, 100));
        step();
        btn_reset = 1'b1;
        repeat (70) run_to_tick();
        chk("needs_30", needs, pk(30, 30, 30));
        chk("life_at_30", life, 32'd100);
        run_to_tick();
        chk("life_97", life, 32'd97);
        chk("needs_29", needs, pk(29, 29, 29));
        run_to_tick();
        chk("life_94", life, 32'd94);
        act_valid = 1'b1;
        act_heal  = 1'b1;
        step();
        act_valid = 1'b0;
        chk("heal_healthy_err", {31'd0, act_err}, 32'd1);
        chk("heal_ready_low", {31'd0, act_ready}, 32'd0);
        step();
        chk("heal_err_cleared", {31'd0, act_err}, 32'd0);
        chk("heal_no_change", life, 32'd94);
        run_to_tick();
        chk("life_91", life, 32'd91);
        repeat (24) run_to_tick();
        chk("life_19", life, 32'd19);
        chk("disease_lag", {31'd0, disease}, 32'd0);
        step();
        chk("disease_set", {31'd0, disease}, 32'd1);
        act_valid = 1'b1;
        act_heal  = 1'b1;
        step();
        act_valid = 1'b0;
        chk("heal_sick_no_err", {31'd0, act_err}, 32'd0);
        step();
        chk("heal_life_59", life, 32'd59);
        step();
        chk("life_56", life, 32'd56);
        chk("disease_clear", {31'd0, disease}, 32'd0);
        repeat (18) run_to_tick();
        chk("life_2", life, 32'd2);
        chk("needs_0", needs, pk(0, 0, 0));
        run_to_tick();
        chk("life_0", life, 32'd0);
        chk("death_lag", {31'd0, death}, 32'd0);
        chk("ready_life0", {31'd0, act_ready}, 32'd0);
        step();
        chk("death_set", {31'd0, death}, 32'd1);
        chk("ready_dead", {31'd0, act_ready}, 32'd0);
        act_valid = 1'b1;
        act_heal  = 1'b1;
        run_to_tick();
        chk("dead_life", life, 32'd0);
        chk("dead_err", {31'd0, act_err}, 32'd0);
        chk("dead_ready", {31'd0, act_ready}, 32'd0);
        chk("dead_sticky", {31'd0, death}, 32'd1);
        act_valid = 1'b0;

        // ---------------- bad index, reset during cooldown ----------------
        btn_reset = 1'b0;
        #1;
        chk("rst3_death", {31'd0, death}, 32'd0);
        chk("rst3_life", life, 32'd100);
        chk("rst3_ready", {31'd0, act_ready}, 32'd0);
        step();
        btn_reset = 1'b1;
        step();
        chk("rst3_ready_up", {31'd0, act_ready}, 32'd1);
        act_valid = 1'b1;
        act_heal  = 1'b0;
        act_need  = 2'd3;
        step();
        act_valid = 1'b0;
        chk("bad_idx_err", {31'd0, act_err}, 32'd1);
        step();
        chk("bad_idx_err_clr", {31'd0, act_err}, 32'd0);
        chk("bad_idx_needs", needs, pk(100, 100, 100));
        step();
        btn_reset = 1'b0;
        #1;
        chk("rst_cool_ready", {31'd0, act_ready}, 32'd0);
        step();
        step();
        btn_reset = 1'b1;
        chk("rst4_ready_pre", {31'd0, act_ready}, 32'd0);
        step();
        chk("rst4_ready", {31'd0, act_ready}, 32'd1);
        chk("rst4_needs", needs, pk(100, 100, 100));
        chk("rst4_life", life, 32'd100);
        step();
        chk("rst4_no_pending", {31'd0, act_err}, 32'd0);
        chk("rst4_ready_hold", {31'd0, act_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pet_needs_engine
`default_nettype wire
